// File: rtl/matrix_alu_pkg.sv
// Shared definitions for the parametrised matrix ALU: op-codes, FSM state
// encoding and op-code classification helpers.
package matrix_alu_pkg;

    localparam logic [2:0] OP_TRANS = 3'd0;
    localparam logic [2:0] OP_SCAL  = 3'd1;
    localparam logic [2:0] OP_ADD   = 3'd2;
    localparam logic [2:0] OP_MUL   = 3'd3;
    localparam logic [2:0] OP_SUB   = 3'd4;
    localparam logic [2:0] OP_HAD   = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_COMPUTE,
        ST_DRAIN,
        ST_FINISH
    } state_t;

    // Op-codes 6 and 7 have no defined operation.
    function automatic logic op_illegal(input logic [2:0] op);
        return op > OP_HAD;
    endfunction

    // Element-wise binary ops need both operands to have identical shape.
    function automatic logic op_same_shape(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_HAD);
    endfunction

endpackage

// File: rtl/matrix_alu_mac_pipe.sv
// Two-stage multiply-accumulate pipe used by matrix multiply: a registered
// product followed by an accumulator that loads (rather than adds) the first
// term of each dot product. flushed marks the cycle after the last product
// has landed in the accumulator.
module mac_pipe #(
    parameter int DW    = 8,
    parameter int ACC_W = 19
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue,
    input  logic             first,
    input  logic             clr,
    input  logic [DW-1:0]    a,
    input  logic [DW-1:0]    b,
    output logic [ACC_W-1:0] acc,
    output logic             flushed
);

    logic [2*DW-1:0]  prod_p1;
    logic             first_p1;
    logic             vld_p1;
    logic             vld_p2;
    logic [ACC_W-1:0] acc_p2;

    // Stage 1: register the full-width product together with its tags.
    always_ff @(posedge clk) begin
        if (rst) begin
            prod_p1  <= '0;
            first_p1 <= 1'b0;
            vld_p1   <= 1'b0;
        end else begin
            prod_p1  <= (2*DW)'(a) * (2*DW)'(b);
            first_p1 <= first;
            vld_p1   <= issue;
        end
    end

    // Stage 2: accumulate valid products; the first term of a dot product loads.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_p2 <= '0;
            vld_p2 <= 1'b0;
        end else begin
            vld_p2 <= vld_p1;
            if (vld_p1)
                acc_p2 <= first_p1 ? ACC_W'(prod_p1) : acc_p2 + ACC_W'(prod_p1);
            else if (clr)
                acc_p2 <= '0;
        end
    end

    assign acc     = acc_p2;
    assign flushed = vld_p2 & ~vld_p1;

endmodule

// File: rtl/matrix_alu_p.sv
// Parametrised matrix ALU: transpose, scalar multiply, add, subtract,
// Hadamard and matrix multiply on snapshotted operands, with optional
// saturation and a start/done handshake.
module matrix_alu_p
    import matrix_alu_pkg::*;
#(
    parameter int DW      = 8,
    parameter int MAX_DIM = 5,
    parameter int DIM_W   = 3,
    parameter int RW      = 2 * DW
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [2:0]                    op_code,
    input  logic                          sat_en,
    input  logic [MAX_DIM*MAX_DIM*DW-1:0] a_flat,
    input  logic [MAX_DIM*MAX_DIM*DW-1:0] b_flat,
    input  logic [DIM_W-1:0]              m_a,
    input  logic [DIM_W-1:0]              n_a,
    input  logic [DIM_W-1:0]              m_b,
    input  logic [DIM_W-1:0]              n_b,
    input  logic [DW-1:0]                 scalar,
    output logic [MAX_DIM*MAX_DIM*RW-1:0] result_flat,
    output logic [DIM_W-1:0]              result_m,
    output logic [DIM_W-1:0]              result_n,
    output logic                          done,
    output logic                          valid,
    output logic                          busy
);

    localparam int ACC_W = 2 * DW + $clog2(MAX_DIM);
    localparam int XW    = ACC_W + 1;
    localparam int IW    = 2 * DIM_W;
    localparam logic signed [XW-1:0] SAT_MAX = XW'((1 << DW) - 1);

    // Clamp to [0, 2^DW-1] when saturating, otherwise keep the low RW bits.
    function automatic logic [RW-1:0] fit(input logic signed [XW-1:0] v, input logic sat);
        if (sat) begin
            if (v < 0)
                return '0;
            else if (v > SAT_MAX)
                return RW'(SAT_MAX);
        end
        return RW'(v);
    endfunction

    function automatic logic dim_ok(input logic [DIM_W-1:0] d);
        return (d != '0) && (d <= DIM_W'(MAX_DIM));
    endfunction

    state_t                         state;
    logic [2:0]                     op_p0;
    logic                           sat_p0;
    logic [DW-1:0]                  sc_p0;
    logic [DIM_W-1:0]               ma_p0, na_p0, mb_p0, nb_p0;
    logic [MAX_DIM*MAX_DIM*DW-1:0]  a_p0, b_p0;
    logic [DIM_W-1:0]               i, j, k;

    logic                           legal;
    logic [IW-1:0]                  idx_e, idx_ak, idx_bk, widx;
    logic [DW-1:0]                  ea, eb, mac_a, mac_b;
    logic signed [XW-1:0]           elem_val;
    logic [ACC_W-1:0]               mac_acc;
    logic                           mac_issue, mac_first, mac_clr, flushed;
    logic                           last_i, last_j, last_k;

    // Snapshot the whole request when a start is accepted.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && start) begin
            op_p0  <= op_code;
            sat_p0 <= sat_en;
            sc_p0  <= scalar;
            ma_p0  <= m_a;
            na_p0  <= n_a;
            mb_p0  <= m_b;
            nb_p0  <= n_b;
            a_p0   <= a_flat;
            b_p0   <= b_flat;
        end
    end

    // Operation legality from the snapshotted op-code and dimensions.
    always_comb begin
        legal = dim_ok(ma_p0) && dim_ok(na_p0);
        if (op_same_shape(op_p0))
            legal = legal && dim_ok(mb_p0) && dim_ok(nb_p0) && (ma_p0 == mb_p0) && (na_p0 == nb_p0);
        if (op_p0 == OP_MUL)
            legal = legal && dim_ok(mb_p0) && dim_ok(nb_p0) && (na_p0 == mb_p0);
        if (op_illegal(op_p0))
            legal = 1'b0;
    end

    // Operand addressing, element value and destination index.
    always_comb begin
        idx_e  = IW'(i) * IW'(na_p0) + IW'(j);
        idx_ak = IW'(i) * IW'(na_p0) + IW'(k);
        idx_bk = IW'(k) * IW'(nb_p0) + IW'(j);
        ea     = a_p0[idx_e*DW +: DW];
        eb     = b_p0[idx_e*DW +: DW];
        mac_a  = a_p0[idx_ak*DW +: DW];
        mac_b  = b_p0[idx_bk*DW +: DW];
        widx   = idx_e;
        case (op_p0)
            OP_TRANS: begin
                elem_val = $signed(XW'(ea));
                widx     = IW'(j) * IW'(ma_p0) + IW'(i);
            end
            OP_SCAL: elem_val = $signed(XW'(ea) * XW'(sc_p0));
            OP_ADD:  elem_val = $signed(XW'(ea)) + $signed(XW'(eb));
            OP_SUB:  elem_val = $signed(XW'(ea)) - $signed(XW'(eb));
            OP_HAD:  elem_val = $signed(XW'(ea) * XW'(eb));
            OP_MUL: begin
                elem_val = $signed({1'b0, mac_acc});
                widx     = IW'(i) * IW'(nb_p0) + IW'(j);
            end
            default: elem_val = '0;
        endcase
    end

    assign last_i    = (i == ma_p0 - DIM_W'(1));
    assign last_j    = (j == ((op_p0 == OP_MUL) ? nb_p0 : na_p0) - DIM_W'(1));
    assign last_k    = (k == na_p0 - DIM_W'(1));
    assign mac_issue = (state == ST_COMPUTE) && (op_p0 == OP_MUL);
    assign mac_first = (k == '0);
    assign mac_clr   = (state == ST_DRAIN) && flushed;

    mac_pipe #(
        .DW    (DW),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk     (clk),
        .rst     (rst),
        .issue   (mac_issue),
        .first   (mac_first),
        .clr     (mac_clr),
        .a       (mac_a),
        .b       (mac_b),
        .acc     (mac_acc),
        .flushed (flushed)
    );

    // Control FSM: sequencing, index counters, result writes and handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            i           <= '0;
            j           <= '0;
            k           <= '0;
            done        <= 1'b0;
            valid       <= 1'b1;
            busy        <= 1'b0;
            result_flat <= '0;
            result_m    <= '0;
            result_n    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy  <= 1'b1;
                        i     <= '0;
                        j     <= '0;
                        k     <= '0;
                        state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    valid <= legal;
                    if (legal) begin
                        result_flat <= '0;
                        result_m    <= (op_p0 == OP_TRANS) ? na_p0 : ma_p0;
                        result_n    <= (op_p0 == OP_TRANS) ? ma_p0 :
                                       (op_p0 == OP_MUL)   ? nb_p0 : na_p0;
                        state       <= ST_COMPUTE;
                    end else begin
                        state <= ST_FINISH;
                    end
                end
                ST_COMPUTE: begin
                    if (op_p0 == OP_MUL) begin
                        if (last_k) begin
                            k     <= '0;
                            state <= ST_DRAIN;
                        end else begin
                            k <= k + DIM_W'(1);
                        end
                    end else begin
                        result_flat[widx*RW +: RW] <= fit(elem_val, sat_p0);
                        if (last_j) begin
                            j <= '0;
                            i <= i + DIM_W'(1);
                        end else begin
                            j <= j + DIM_W'(1);
                        end
                        if (last_j && last_i)
                            state <= ST_FINISH;
                    end
                end
                ST_DRAIN: begin
                    if (flushed) begin
                        result_flat[widx*RW +: RW] <= fit(elem_val, sat_p0);
                        if (last_j) begin
                            j <= '0;
                            i <= i + DIM_W'(1);
                        end else begin
                            j <= j + DIM_W'(1);
                        end
                        state <= (last_j && last_i) ? ST_FINISH : ST_COMPUTE;
                    end
                end
                ST_FINISH: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_alu_p.sv
// Self-checking bench for matrix_alu_p: directed scenarios plus randomized
// operations compared against a plain-arithmetic matrix model.
module tb_matrix_alu_p;

    localparam int DW = 8, MAX_DIM = 5, DIM_W = 3, RW = 16, NE = 25;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [2:0]        op_code;
    logic              sat_en;
    logic [NE*DW-1:0]  a_flat, b_flat;
    logic [DIM_W-1:0]  m_a, n_a, m_b, n_b;
    logic [DW-1:0]     scalar;
    logic [NE*RW-1:0]  result_flat;
    logic [DIM_W-1:0]  result_m, result_n;
    logic              done, valid, busy;

    matrix_alu_p #(.DW(DW), .MAX_DIM(MAX_DIM), .DIM_W(DIM_W), .RW(RW)) dut (
        .clk(clk), .rst(rst), .start(start), .op_code(op_code), .sat_en(sat_en),
        .a_flat(a_flat), .b_flat(b_flat), .m_a(m_a), .n_a(n_a), .m_b(m_b), .n_b(n_b),
        .scalar(scalar), .result_flat(result_flat), .result_m(result_m),
        .result_n(result_n), .done(done), .valid(valid), .busy(busy)
    );

    always #5 clk = ~clk;

    int A[5][5];
    int B[5][5];
    logic [NE*RW-1:0] mdl_flat;
    int mdl_m, mdl_n;
    int total = 0, bad = 0;
    int cyc;

    function automatic int fitv(input int v, input int sat);
        if (sat != 0) return (v < 0) ? 0 : (v > 255) ? 255 : v;
        return v & 32'hFFFF;
    endfunction

    function automatic bit dok(input int d);
        return d >= 1 && d <= MAX_DIM;
    endfunction

    task automatic clear_ops();
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) begin
                A[r][c] = 0;
                B[r][c] = 0;
            end
    endtask

    task automatic model_reset();
        mdl_flat = '0;
        mdl_m = 0;
        mdl_n = 0;
    endtask

    // Matrix semantics written directly from the operation definitions.
    task automatic model(input int op, sat, ma, na, mb, nb, sc, output bit legal, output int ncyc);
        logic [NE*RW-1:0] f;
        int v, cols, pos;
        legal = (op <= 5) && dok(ma) && dok(na);
        if (op == 2 || op == 4 || op == 5)
            legal = legal && dok(mb) && dok(nb) && ma == mb && na == nb;
        if (op == 3)
            legal = legal && dok(mb) && dok(nb) && na == mb;
        ncyc = 2;
        if (!legal) return;
        f = '0;
        cols = (op == 3) ? nb : na;
        for (int r = 0; r < ma; r++)
            for (int c = 0; c < cols; c++) begin
                case (op)
                    0: v = A[r][c];
                    1: v = A[r][c] * sc;
                    2: v = A[r][c] + B[r][c];
                    3: begin
                        v = 0;
                        for (int t = 0; t < na; t++) v += A[r][t] * B[t][c];
                    end
                    4: v = A[r][c] - B[r][c];
                    default: v = A[r][c] * B[r][c];
                endcase
                pos = (op == 0) ? c * ma + r : r * cols + c;
                f[pos*RW +: RW] = 16'(fitv(v, sat));
            end
        mdl_flat = f;
        mdl_m = (op == 0) ? na : ma;
        mdl_n = (op == 0) ? ma : cols;
        ncyc = (op == 3) ? ma * nb * (na + 2) + 2 : ma * na + 2;
    endtask

    task automatic pack(input int na, nb);
        a_flat = '0;
        b_flat = '0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) begin
                if (c < na && r * na + c < NE) a_flat[(r*na+c)*DW +: DW] = 8'(A[r][c]);
                if (c < nb && r * nb + c < NE) b_flat[(r*nb+c)*DW +: DW] = 8'(B[r][c]);
            end
    endtask

    // Drive one request; cycles counts edges from the accepting edge to done.
    task automatic run_op(input int op, sat, ma, na, mb, nb, sc, input bit disturb, output int cycles);
        pack(na, nb);
        op_code = 3'(op);
        sat_en  = (sat != 0);
        m_a = 3'(ma); n_a = 3'(na); m_b = 3'(mb); n_b = 3'(nb);
        scalar = 8'(sc);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (disturb) begin
            a_flat = ~a_flat; b_flat = ~b_flat; scalar = ~scalar;
            op_code = 3'd7; m_a = '0; n_b = 3'd7;
            start = 1'b1;
        end
        cycles = -1;
        for (int c = 1; c <= 400 && cycles < 0; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (done === 1'b1) cycles = c;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; op_code = '0; sat_en = 1'b0;
        a_flat = '0; b_flat = '0; m_a = '0; n_a = '0; m_b = '0; n_b = '0; scalar = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        total++; if (result_flat !== '0) begin bad++; $display("FAIL reset_result got %h want 0", result_flat); end
        total++; if (result_m !== 3'd0 || result_n !== 3'd0) begin bad++; $display("FAIL reset_dims got %0dx%0d want 0x0", result_m, result_n); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got %b want 0", done); end
        total++; if (valid !== 1'b1) begin bad++; $display("FAIL reset_valid got %b want 1", valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_matmul();
        logic [NE*RW-1:0] e;
        clear_ops();
        A[0][0] = 1; A[0][1] = 2; A[0][2] = 3; A[1][0] = 4; A[1][1] = 5; A[1][2] = 6;
        B[0][0] = 7; B[0][1] = 8; B[1][0] = 9; B[1][1] = 10; B[2][0] = 11; B[2][1] = 12;
        e = '0;
        e[0*RW +: RW] = 16'd58;  e[1*RW +: RW] = 16'd64;
        e[2*RW +: RW] = 16'd139; e[3*RW +: RW] = 16'd154;
        run_op(3, 0, 2, 3, 3, 2, 0, 1'b0, cyc);
        total++; if (cyc !== 22) begin bad++; $display("FAIL matmul_latency got %0d want 22", cyc); end
        total++; if (result_flat !== e) begin bad++; $display("FAIL matmul_result got %h want %h", result_flat, e); end
        total++; if (result_m !== 3'd2 || result_n !== 3'd2) begin bad++; $display("FAIL matmul_dims got %0dx%0d want 2x2", result_m, result_n); end
        total++; if (valid !== 1'b1) begin bad++; $display("FAIL matmul_valid got %b want 1", valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL matmul_busy_at_done got %b want 0", busy); end
        @(posedge clk); #1;
        total++; if (done !== 1'b0) begin bad++; $display("FAIL done_pulse_width got %b want 0", done); end
        mdl_flat = e; mdl_m = 2; mdl_n = 2;
    endtask

    task automatic test_add();
        logic [NE*RW-1:0] e;
        clear_ops();
        A[0][0] = 200; A[0][1] = 10; B[0][0] = 100; B[0][1] = 5;
        run_op(2, 1, 1, 2, 1, 2, 0, 1'b0, cyc);
        e = '0; e[0 +: RW] = 16'd255; e[RW +: RW] = 16'd15;
        total++; if (result_flat !== e || cyc !== 4) begin bad++; $display("FAIL add_sat got %h/%0d want %h/4", result_flat, cyc, e); end
        run_op(2, 0, 1, 2, 1, 2, 0, 1'b0, cyc);
        e = '0; e[0 +: RW] = 16'd300; e[RW +: RW] = 16'd15;
        total++; if (result_flat !== e || cyc !== 4) begin bad++; $display("FAIL add_wrap got %h/%0d want %h/4", result_flat, cyc, e); end
    endtask

    task automatic test_sub_had();
        logic [NE*RW-1:0] e;
        clear_ops();
        A[0][0] = 5; B[0][0] = 9;
        run_op(4, 1, 1, 1, 1, 1, 0, 1'b0, cyc);
        total++; if (result_flat !== '0 || cyc !== 3) begin bad++; $display("FAIL sub_sat got %h/%0d want 0/3", result_flat, cyc); end
        run_op(4, 0, 1, 1, 1, 1, 0, 1'b0, cyc);
        e = '0; e[0 +: RW] = 16'hFFFC;
        total++; if (result_flat !== e) begin bad++; $display("FAIL sub_wrap got %h want %h", result_flat, e); end
        A[0][0] = 3; A[0][1] = 4; B[0][0] = 5; B[0][1] = 6;
        run_op(5, 1, 1, 2, 1, 2, 0, 1'b0, cyc);
        e = '0; e[0 +: RW] = 16'd15; e[RW +: RW] = 16'd24;
        total++; if (result_flat !== e) begin bad++; $display("FAIL hadamard got %h want %h", result_flat, e); end
    endtask

    task automatic test_transpose();
        logic [NE*RW-1:0] e;
        clear_ops();
        e = '0;
        for (int c = 0; c < 5; c++) begin
            A[0][c] = c + 1;
            e[c*RW +: RW] = 16'(c + 1);
        end
        run_op(0, 0, 1, 5, 1, 1, 0, 1'b1, cyc);
        total++; if (result_flat !== e) begin bad++; $display("FAIL transpose_snapshot got %h want %h", result_flat, e); end
        total++; if (result_m !== 3'd5 || result_n !== 3'd1 || cyc !== 7) begin bad++; $display("FAIL transpose_shape got %0dx%0d/%0d want 5x1/7", result_m, result_n, cyc); end
        mdl_flat = e; mdl_m = 5; mdl_n = 1;
    endtask

    task automatic test_illegal();
        int ops[3] = '{3, 6, 2};
        int mas[3] = '{2, 1, 0};
        int nas[3] = '{3, 1, 2};
        int mbs[3] = '{2, 1, 0};
        int nbs[3] = '{2, 1, 2};
        for (int t = 0; t < 3; t++) begin
            run_op(ops[t], 0, mas[t], nas[t], mbs[t], nbs[t], 1, 1'b1, cyc);
            total++; if (cyc !== 2 || valid !== 1'b0) begin bad++; $display("FAIL illegal_%0d got cyc=%0d valid=%b want cyc=2 valid=0", t, cyc, valid); end
            total++; if (result_flat !== mdl_flat || result_m !== 3'(mdl_m) || result_n !== 3'(mdl_n)) begin
                bad++; $display("FAIL illegal_keep_%0d got %h %0dx%0d want %h %0dx%0d", t, result_flat, result_m, result_n, mdl_flat, mdl_m, mdl_n);
            end
        end
    endtask

    task automatic test_reset_midway();
        logic [NE*RW-1:0] e;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) begin
                A[r][c] = $urandom_range(0, 255);
                B[r][c] = $urandom_range(0, 255);
            end
        pack(5, 5);
        op_code = 3'd3; sat_en = 1'b0; m_a = 3'd5; n_a = 3'd5; m_b = 3'd5; n_b = 3'd5;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL busy_mid_op got %b want 1", busy); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        total++; if (result_flat !== '0 || result_m !== 3'd0 || result_n !== 3'd0) begin
            bad++; $display("FAIL abort_result got %h %0dx%0d want 0 0x0", result_flat, result_m, result_n);
        end
        total++; if (done !== 1'b0 || valid !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL abort_ctrl got done=%b valid=%b busy=%b want 0 1 0", done, valid, busy);
        end
        clear_ops();
        A[0][0] = 7;
        run_op(1, 0, 1, 1, 1, 1, 3, 1'b0, cyc);
        e = '0; e[0 +: RW] = 16'd21;
        total++; if (result_flat !== e || cyc !== 3) begin bad++; $display("FAIL after_abort got %h/%0d want %h/3", result_flat, cyc, e); end
    endtask

    task automatic test_back_to_back();
        bit lg;
        int nc;
        for (int t = 0; t < 3; t++) begin
            for (int r = 0; r < 5; r++)
                for (int c = 0; c < 5; c++) begin
                    A[r][c] = $urandom_range(0, 255);
                    B[r][c] = $urandom_range(0, 255);
                end
            model(t + 1, 0, 2, 2, 2, 2, 9, lg, nc);
            run_op(t + 1, 0, 2, 2, 2, 2, 9, 1'b0, cyc);
            total++; if (cyc !== nc || result_flat !== mdl_flat) begin
                bad++; $display("FAIL back_to_back_%0d got %h/%0d want %h/%0d", t, result_flat, cyc, mdl_flat, nc);
            end
        end
    endtask

    task automatic test_random();
        bit lg;
        int nc, op, sat, ma, na, mb, nb, sc;
        for (int t = 0; t < 24; t++) begin
            op  = $urandom_range(0, 7);
            sat = $urandom_range(0, 1);
            sc  = $urandom_range(0, 255);
            ma  = $urandom_range(1, 5);
            na  = $urandom_range(1, 5);
            mb  = ma;
            nb  = na;
            if (op == 3) begin mb = na; nb = $urandom_range(1, 5); end
            if ($urandom_range(0, 7) == 0) begin
                ma = $urandom_range(0, 7); na = $urandom_range(0, 7);
                mb = $urandom_range(0, 7); nb = $urandom_range(0, 7);
            end
            for (int r = 0; r < 5; r++)
                for (int c = 0; c < 5; c++) begin
                    A[r][c] = $urandom_range(0, 255);
                    B[r][c] = $urandom_range(0, 255);
                end
            model(op, sat, ma, na, mb, nb, sc, lg, nc);
            run_op(op, sat, ma, na, mb, nb, sc, 1'b0, cyc);
            total++; if (cyc !== nc || valid !== lg) begin
                bad++; $display("FAIL rand_%0d_ctrl op=%0d got cyc=%0d valid=%b want cyc=%0d valid=%b", t, op, cyc, valid, nc, lg);
            end
            total++; if (result_flat !== mdl_flat || result_m !== 3'(mdl_m) || result_n !== 3'(mdl_n)) begin
                bad++; $display("FAIL rand_%0d_data op=%0d got %h %0dx%0d want %h %0dx%0d", t, op, result_flat, result_m, result_n, mdl_flat, mdl_m, mdl_n);
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_matmul();
        test_add();
        test_sub_had();
        test_transpose();
        test_illegal();
        test_reset_midway();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/matrix_alu_p.md
# matrix_alu_p

Parametrised next-generation matrix ALU for the calculation subsystem, sitting between the operand store / input parser and the 16-bit matrix printer. It generalises element width and maximum dimension, and snapshots both operands at start. It adds subtract and element-wise (Hadamard) multiply, selectable saturating or modular arithmetic, and a two-stage MAC pipeline for matrix multiply. It uses a single start/done handshake and reports operand legality through `valid`.

## Interface
- `DW`, default 8: operand element width.
- `MAX_DIM`, default 5: maximum rows or columns per matrix.
- `DIM_W`, default 3: width of dimension ports; must satisfy 2^DIM_W > MAX_DIM.
- `RW`, default 2*DW: result element width.
- `clk`, in, 1: single clock; all logic on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: request an operation; sampled only in IDLE.
- `op_code`, in, 3: 0 transpose, 1 scalar multiply, 2 add, 3 matrix multiply, 4 subtract (A−B), 5 Hadamard; 6 and 7 are illegal.
- `sat_en`, in, 1: 1 clamps results to 2^DW−1 (and subtract to 0); 0 gives modular RW-bit results.
- `a_flat`, `b_flat`, in, MAX_DIM*MAX_DIM*DW: operands, compact row-major; element (r,c) is at bit offset (r*cols+c)*DW.
- `m_a`, `n_a`, `m_b`, `n_b`, in, DIM_W: operand dimensions.
- `scalar`, in, DW: scalar operand for op 1.
- `result_flat`, out, MAX_DIM*MAX_DIM*RW: result, compact row-major, RW per element.
- `result_m`, `result_n`, out, DIM_W: result dimensions.
- `done`, out, 1: one-cycle completion pulse.
- `valid`, out, 1: legality of the last accepted operation; held until the next start.
- `busy`, out, 1: high from the cycle after start is accepted until `done`.

## Operation
- Reset values: `result_flat`=0, `result_m`=`result_n`=0, `done`=0, `valid`=1, `busy`=0, state=IDLE, MAC pipe cleared.
- On start in IDLE, latch `op_code`, `sat_en`, `scalar`, all dimensions and both operand buses into internal snapshot registers. Inputs may change afterwards without effect.
- Legality check:
  - Every used dimension must be in 1..MAX_DIM. A zero dimension is illegal.
  - Ops 2, 4 and 5 also require m_a=m_b and n_a=n_b.
  - Op 3 also requires n_a=m_b.
  - Ops 6 and 7 are always illegal.
- States: IDLE → CHECK → COMPUTE → DRAIN (op 3 only, per output element) → FINISH → IDLE.
  - CHECK: latches `valid` and goes directly to FINISH if the operation is illegal.
  - CHECK, legal case: clears `result_flat` to 0.
- Element ops (0, 1, 2, 4, 5) write one element per cycle, row-major over (i,j).
  - Transpose writes result (j,i) using a result column count of m_a.
  - Result dimensions are n_a×m_a for transpose and m_a×n_a otherwise.
- Matrix multiply, per output element (i,j):
  - Issue one product a(i,k)*b(k,j) per cycle for k=0..n_a−1.
  - Stage 1 registers the 2*DW-bit product. Stage 2 accumulates into an accumulator of width 2*DW+clog2(MAX_DIM).
  - DRAIN waits 2 cycles for the pipeline to flush, then writes the result and clears the accumulator.
  - Result dimensions are m_a×n_b.
- Arithmetic:
  - `sat_en`=1: any value above 2^DW−1 becomes 2^DW−1; a negative subtract result becomes 0.
  - `sat_en`=0: results are truncated to the low RW bits (two's-complement wrap for subtract).
- Illegal operation: `result_flat`, `result_m` and `result_n` keep their previous values; `valid`=0.
- A start pulse while not in IDLE is ignored; no queueing.
- Assertion of `rst` at any point, including mid-operation, aborts the operation and restores all reset values on the next edge.

## Timing
- Start is sampled at edge 0. `busy`=1 from edge 1 through the cycle before `done`.
- `done` pulses at edge N and `busy` falls at the same edge. `valid` and the result are stable when `done`=1.
- N = 2 for an illegal operation.
- N = m*n + 2 for element ops, where m and n are the operand dimensions.
- N = m_a*n_b*(n_a+2) + 2 for matrix multiply.
- Back-to-back: start may be asserted in the cycle `done` is high; it is accepted on the following edge, since the block is then in IDLE.

## Structure
- Package `matrix_alu_pkg` holds the op-code constants, the state encoding, and the illegal-op predicate function.
- Sub-module `mac_pipe`, parametrised by DW and ACC_W, contains the product register, the accumulator, the first-term load and the 2-deep valid shift used for DRAIN.
- The top level contains the snapshot registers, the index counters i/j/k and the FSM.

## Test plan
- Op 3, sat_en=0, A=[[1,2,3],[4,5,6]], B=[[7,8],[9,10],[11,12]] → result [[58,64],[139,154]], result dimensions 2×2, `done` at edge 22, `valid`=1.
- Op 2, 1×2, A=[200,10], B=[100,5]: sat_en=1 → [255,15]; sat_en=0 → [300,15].
- Op 4, 1×1, A=5, B=9: sat_en=1 → 0; sat_en=0 → 16'hFFFC. Op 5, A=[3,4], B=[5,6] → [15,24].
- Op 0, 1×5, A=[1..5] → 5×1 result [1..5]. Drive new values on `a_flat` after start → result unchanged.
- Op 3 with 2×3 × 2×2 operands, then op 6, then a zero dimension → each gives `done` at edge 2 with `valid`=0 and the previous result retained. Start pulses while `busy` are ignored.
- Assert `rst` midway through a 5×5×5 multiply → next edge: all outputs at reset values. A following 1×1 op 1 with A=7, scalar=3 → result 21.
